// File: rtl/pcs_tx_framer.sv
`default_nettype none
// ============================================================================
// Module      : pcs_tx_framer
// Description : PCS transmit framer. Sequences a frame through SSD, DATA,
//               CSR and ESD symbol classes with optional carrier extension.
//               It also runs a side-stream LFSR scrambler with a selectable
//               master or slave feedback tap.
// Ports       : clock, reset (async active-low)
//               io_tx_enable/io_tx_error/io_tx_data   - GMII-side transmit
//               io_tx_mode       - 0 SEND_Z, 1 SEND_I, 2 SEND_N, 3 as SEND_Z
//               io_master        - scrambler tap select (1 = TAP_M)
//               io_loc_rcvr_status - gates new frame starts
//               io_kind          - registered symbol class code
//               io_sym           - registered framing symbols, lane 0 in MSBs
//               io_data_out      - registered scrambled data word
//               io_busy          - FSM outside IDLE/ZERO
// Revision    : 1.0 - initial release
// ============================================================================
module pcs_tx_framer #(
    parameter int               LANES  = 4,
    parameter int               SYM_W  = 3,
    parameter int               DATA_W = 8,
    parameter int               SCR_W  = 33,
    parameter int               TAP_M  = 13,
    parameter int               TAP_S  = 20,
    parameter logic [SCR_W-1:0] SEED   = SCR_W'(1)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   io_tx_enable,
    input  logic                   io_tx_error,
    input  logic [DATA_W-1:0]      io_tx_data,
    input  logic [1:0]             io_tx_mode,
    input  logic                   io_master,
    input  logic                   io_loc_rcvr_status,
    output logic [3:0]             io_kind,
    output logic [LANES*SYM_W-1:0] io_sym,
    output logic [DATA_W-1:0]      io_data_out,
    output logic                   io_busy
);

    localparam logic [3:0] ST_ZERO = 4'd0;
    localparam logic [3:0] ST_IDLE = 4'd1;
    localparam logic [3:0] ST_SSD1 = 4'd2;
    localparam logic [3:0] ST_SSD2 = 4'd3;
    localparam logic [3:0] ST_DATA = 4'd4;
    localparam logic [3:0] ST_CSR1 = 4'd5;
    localparam logic [3:0] ST_CSR2 = 4'd6;
    localparam logic [3:0] ST_ESD1 = 4'd7;
    localparam logic [3:0] ST_ESD2 = 4'd8;
    localparam logic [3:0] ST_CEXT = 4'd9;

    localparam logic [3:0] K_ZERO      = 4'd0;
    localparam logic [3:0] K_IDLE      = 4'd1;
    localparam logic [3:0] K_SSD1      = 4'd2;
    localparam logic [3:0] K_SSD2      = 4'd3;
    localparam logic [3:0] K_DATA      = 4'd4;
    localparam logic [3:0] K_CSR1      = 4'd5;
    localparam logic [3:0] K_CSR2      = 4'd6;
    localparam logic [3:0] K_ESD1      = 4'd7;
    localparam logic [3:0] K_ESD2_EXT0 = 4'd8;
    localparam logic [3:0] K_ESD2_EXT1 = 4'd9;
    localparam logic [3:0] K_ESD2_EXT2 = 4'd10;
    localparam logic [3:0] K_ESD2_ERR  = 4'd11;
    localparam logic [3:0] K_CEXT      = 4'd12;
    localparam logic [3:0] K_CEXT_ERR  = 4'd13;
    localparam logic [3:0] K_XMT_ERR   = 4'd14;

    localparam logic [SYM_W-1:0]  SYM_P     = SYM_W'(2);
    localparam logic [SYM_W-1:0]  SYM_M     = SYM_W'(-2);
    localparam logic [DATA_W-1:0] CODE_EXT1 = DATA_W'(8'h0F);
    localparam logic [DATA_W-1:0] CODE_EXT2 = DATA_W'(8'h1F);

    logic [3:0]             state;
    logic [3:0]             next_state;
    logic [3:0]             next_kind;
    logic [LANES*SYM_W-1:0] next_sym;
    logic [DATA_W-1:0]      next_data;
    logic                   next_busy;
    logic [SYM_W-1:0]       lane_val;
    logic [SCR_W-1:0]       scr;
    logic [SCR_W-1:0]       scr_next;
    logic                   feedback;
    logic                   mode_zero;

    assign mode_zero = (io_tx_mode == 2'd0) || (io_tx_mode == 2'd3);

    // Tap selection follows io_master on every shift; the register is never reseeded.
    assign feedback = scr[SCR_W-1] ^ (io_master ? scr[TAP_M-1] : scr[TAP_S-1]);
    assign scr_next = {scr[SCR_W-2:0], feedback};

    // ---------------- state register ----------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ST_ZERO;
        end else begin
            state <= next_state;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        next_state = state;
        case (state)
            ST_ZERO: next_state = ST_IDLE;
            ST_IDLE: begin
                if (io_tx_enable && (io_tx_mode == 2'd2) && io_loc_rcvr_status)
                    next_state = ST_SSD1;
            end
            ST_SSD1: next_state = ST_SSD2;
            ST_SSD2,
            ST_DATA: next_state = io_tx_enable ? ST_DATA : ST_CSR1;
            ST_CSR1: next_state = ST_CSR2;
            ST_CSR2: next_state = ST_ESD1;
            ST_ESD1: next_state = ST_ESD2;
            // The registered kind records which ESD2 variant was sent.
            ST_ESD2: begin
                if ((io_kind == K_ESD2_EXT1) || (io_kind == K_ESD2_EXT2))
                    next_state = ST_CEXT;
                else
                    next_state = ST_IDLE;
            end
            ST_CEXT: next_state = io_tx_error ? ST_CEXT : ST_IDLE;
            default: next_state = ST_ZERO;
        endcase
        if (mode_zero)
            next_state = ST_ZERO;
    end

    // ---------------- output logic (values for the next registered cycle) ----------------
    always_comb begin
        next_kind = K_ZERO;
        next_data = scr_next[DATA_W-1:0];
        next_busy = 1'b1;
        case (next_state)
            ST_ZERO: begin
                next_kind = K_ZERO;
                next_data = '0;
                next_busy = 1'b0;
            end
            ST_IDLE: begin
                next_kind = K_IDLE;
                next_busy = 1'b0;
            end
            ST_SSD1: next_kind = K_SSD1;
            ST_SSD2: next_kind = K_SSD2;
            ST_DATA: begin
                next_kind = io_tx_error ? K_XMT_ERR : K_DATA;
                next_data = io_tx_data ^ scr_next[DATA_W-1:0];
            end
            ST_CSR1: next_kind = K_CSR1;
            ST_CSR2: next_kind = K_CSR2;
            ST_ESD1: next_kind = K_ESD1;
            ST_ESD2: begin
                if (!io_tx_error)
                    next_kind = K_ESD2_EXT0;
                else if (io_tx_data == CODE_EXT1)
                    next_kind = K_ESD2_EXT1;
                else if (io_tx_data == CODE_EXT2)
                    next_kind = K_ESD2_EXT2;
                else
                    next_kind = K_ESD2_ERR;
            end
            ST_CEXT: next_kind = (io_tx_data == CODE_EXT1) ? K_CEXT : K_CEXT_ERR;
            default: begin
                next_kind = K_ZERO;
                next_data = '0;
                next_busy = 1'b0;
            end
        endcase
    end

    // Framing symbols derived from the class; lane 0 is packed into the MSBs.
    always_comb begin
        next_sym = '0;
        lane_val = '0;
        for (int i = 0; i < LANES; i++) begin
            case (next_kind)
                K_SSD1, K_ESD1:          lane_val = SYM_P;
                K_SSD2, K_ESD2_EXT0:     lane_val = (i == LANES - 1) ? SYM_M : SYM_P;
                K_ESD2_EXT1:             lane_val = (i == LANES - 2) ? SYM_M : SYM_P;
                K_ESD2_EXT2:             lane_val = (i == 1) ? SYM_M : SYM_P;
                K_ESD2_ERR:              lane_val = (i == 0) ? SYM_M : SYM_P;
                K_XMT_ERR:               lane_val = SYM_M;
                default:                 lane_val = '0;
            endcase
            next_sym[(LANES-1-i)*SYM_W +: SYM_W] = lane_val;
        end
    end

    // ---------------- output and scrambler registers ----------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            io_kind     <= K_ZERO;
            io_sym      <= '0;
            io_data_out <= '0;
            io_busy     <= 1'b0;
        end else begin
            io_kind     <= next_kind;
            io_sym      <= next_sym;
            io_data_out <= next_data;
            io_busy     <= next_busy;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            scr <= SEED;
        end else begin
            scr <= scr_next;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pcs_tx_framer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pcs_tx_framer
// Description : Self-checking bench for pcs_tx_framer. Each stimulus cycle
//               pushes the expected class, symbols, busy flag and scrambled
//               data onto a scoreboard that is popped one edge later.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pcs_tx_framer;

    logic        clock = 1'b0;
    logic        reset;
    logic        io_tx_enable;
    logic        io_tx_error;
    logic [7:0]  io_tx_data;
    logic [1:0]  io_tx_mode;
    logic        io_master;
    logic        io_loc_rcvr_status;
    logic [3:0]  io_kind;
    logic [11:0] io_sym;
    logic [7:0]  io_data_out;
    logic        io_busy;

    pcs_tx_framer dut (
        .clock              (clock),
        .reset              (reset),
        .io_tx_enable       (io_tx_enable),
        .io_tx_error        (io_tx_error),
        .io_tx_data         (io_tx_data),
        .io_tx_mode         (io_tx_mode),
        .io_master          (io_master),
        .io_loc_rcvr_status (io_loc_rcvr_status),
        .io_kind            (io_kind),
        .io_sym             (io_sym),
        .io_data_out        (io_data_out),
        .io_busy            (io_busy)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [3:0]  kind;
        logic [11:0] sym;
        logic [7:0]  data;
        logic        busy;
        logic        chk_data;
    } exp_t;

    exp_t        sb[$];
    int          vectors     = 0;
    int          miscompares = 0;
    logic [32:0] ref_scr;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", tag, $time, obs, exp);
        end
    endtask

    // Reference x^33 + x^TAP + 1 scrambler, new bit into bit 0.
    function automatic logic [32:0] lfsr_step(input logic [32:0] s, input logic master);
        logic fb;
        fb = s[32] ^ (master ? s[12] : s[19]);
        return {s[31:0], fb};
    endfunction

    // Framing symbols for four 3-bit lanes, lane 0 in the top three bits.
    function automatic logic [11:0] sym_of(input logic [3:0] k);
        case (k)
            4'd2, 4'd7: return 12'h492;
            4'd3, 4'd8: return 12'h496;
            4'd9:       return 12'h4B2;
            4'd10:      return 12'h592;
            4'd11:      return 12'hC92;
            4'd14:      return 12'hDB6;
            default:    return 12'h000;
        endcase
    endfunction

    // Drive one cycle of inputs, predict the output after the edge, compare.
    task automatic step(input logic en, input logic err, input logic [7:0] d,
                        input logic [1:0] mode, input logic master, input logic rcvr,
                        input logic [3:0] k);
        exp_t e;
        exp_t got;
        io_tx_enable       = en;
        io_tx_error        = err;
        io_tx_data         = d;
        io_tx_mode         = mode;
        io_master          = master;
        io_loc_rcvr_status = rcvr;
        ref_scr    = lfsr_step(ref_scr, master);
        e.kind     = k;
        e.sym      = sym_of(k);
        e.busy     = (k > 4'd1);
        e.chk_data = !((k == 4'd2) || (k == 4'd3));
        if (k == 4'd0)
            e.data = 8'h00;
        else if ((k == 4'd4) || (k == 4'd14))
            e.data = d ^ ref_scr[7:0];
        else
            e.data = ref_scr[7:0];
        sb.push_back(e);
        @(posedge clock);
        #1;
        if (sb.size() == 0) begin
            check_eq("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            got = sb.pop_front();
            check_eq("kind", {28'd0, io_kind}, {28'd0, got.kind});
            check_eq("sym", {20'd0, io_sym}, {20'd0, got.sym});
            check_eq("busy", {31'd0, io_busy}, {31'd0, got.busy});
            if (got.chk_data)
                check_eq("data_out", {24'd0, io_data_out}, {24'd0, got.data});
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check_eq({tag, "_kind"}, {28'd0, io_kind}, 32'd0);
        check_eq({tag, "_sym"},  {20'd0, io_sym}, 32'd0);
        check_eq({tag, "_data"}, {24'd0, io_data_out}, 32'd0);
        check_eq({tag, "_busy"}, {31'd0, io_busy}, 32'd0);
    endtask

    initial begin
        reset              = 1'b0;
        io_tx_enable       = 1'b0;
        io_tx_error        = 1'b0;
        io_tx_data         = 8'h00;
        io_tx_mode         = 2'd2;
        io_master          = 1'b1;
        io_loc_rcvr_status = 1'b1;
        ref_scr            = 33'd1;

        // Reset state, both before and across clock edges.
        #1;
        check_zero_outputs("reset0");
        repeat (2) @(posedge clock);
        #1;
        check_zero_outputs("reset_held");
        reset = 1'b1;

        // ZERO -> IDLE, then a six-octet frame.
        step(0, 0, 8'h00, 2'd2, 1, 1, 4'd1);
        for (int i = 0; i < 6; i++)
            step(1, 0, 8'hF0, 2'd2, 1, 1, (i == 0) ? 4'd2 : (i == 1) ? 4'd3 : 4'd4);
        step(0, 0, 8'h00, 2'd2, 1, 1, 4'd5);
        step(0, 0, 8'h00, 2'd2, 1, 1, 4'd6);
        step(0, 0, 8'h00, 2'd2, 1, 1, 4'd7);
        step(0, 0, 8'h00, 2'd2, 1, 1, 4'd8);
        step(0, 0, 8'h00, 2'd2, 1, 1, 4'd1);

        // ESD2_EXT1 then carrier extension (good, then errored), then IDLE.
        step(1, 0, 8'hAA, 2'd2, 1, 1, 4'd2);
        step(0, 0, 8'h00, 2'd2, 1, 1, 4'd3);
        step(0, 0, 8'h00, 2'd2, 1, 1, 4'd5);
        step(0, 0, 8'h00, 2'd2, 1, 1, 4'd6);
        step(0, 0, 8'h00, 2'd2, 1, 1, 4'd7);
        step(0, 1, 8'h0F, 2'd2, 1, 1, 4'd9);
        step(0, 1, 8'h0F, 2'd2, 1, 1, 4'd12);
        step(0, 1, 8'h55, 2'd2, 1, 1, 4'd13);
        step(0, 0, 8'h0F, 2'd2, 1, 1, 4'd1);

        // ESD2_EXT2 then CEXT, back-to-back with the next frame.
        step(1, 0, 8'h00, 2'd2, 1, 1, 4'd2);
        step(1, 0, 8'h00, 2'd2, 1, 1, 4'd3);
        step(0, 0, 8'h00, 2'd2, 1, 1, 4'd5);
        step(0, 0, 8'h00, 2'd2, 1, 1, 4'd6);
        step(0, 0, 8'h00, 2'd2, 1, 1, 4'd7);
        step(0, 1, 8'h1F, 2'd2, 1, 1, 4'd10);
        step(0, 1, 8'h0F, 2'd2, 1, 1, 4'd12);
        step(0, 0, 8'h00, 2'd2, 1, 1, 4'd1);

        // ESD2_ERR returns straight to IDLE; next frame starts immediately.
        step(1, 0, 8'h00, 2'd2, 1, 1, 4'd2);
        step(0, 0, 8'h00, 2'd2, 1, 1, 4'd3);
        step(0, 0, 8'h00, 2'd2, 1, 1, 4'd5);
        step(0, 0, 8'h00, 2'd2, 1, 1, 4'd6);
        step(0, 0, 8'h00, 2'd2, 1, 1, 4'd7);
        step(1, 1, 8'h33, 2'd2, 1, 1, 4'd11);
        step(1, 0, 8'h00, 2'd2, 1, 1, 4'd1);
        step(1, 0, 8'h00, 2'd2, 1, 1, 4'd2);

        // Data error mid-frame, receiver status dropping mid-frame is ignored.
        step(1, 0, 8'h12, 2'd2, 1, 1, 4'd3);
        step(1, 1, 8'h34, 2'd2, 1, 0, 4'd14);
        step(1, 0, 8'h56, 2'd2, 1, 0, 4'd4);
        step(0, 0, 8'h00, 2'd2, 1, 0, 4'd5);
        step(0, 1, 8'h0F, 2'd2, 1, 0, 4'd6);
        step(0, 0, 8'h00, 2'd2, 1, 0, 4'd7);
        step(0, 0, 8'h00, 2'd2, 1, 0, 4'd8);

        // Receiver status low gates new starts.
        step(1, 0, 8'h00, 2'd2, 1, 0, 4'd1);
        step(1, 0, 8'h00, 2'd2, 1, 0, 4'd1);
        // SEND_I does not start a frame either.
        step(1, 0, 8'h00, 2'd1, 1, 1, 4'd1);

        // Mode override aborts a frame during DATA.
        step(1, 0, 8'h77, 2'd2, 1, 1, 4'd2);
        step(1, 0, 8'h77, 2'd2, 1, 1, 4'd3);
        step(1, 0, 8'h77, 2'd2, 1, 1, 4'd4);
        step(1, 0, 8'h77, 2'd0, 1, 1, 4'd0);
        step(1, 0, 8'h77, 2'd2, 1, 1, 4'd1);
        step(1, 0, 8'h77, 2'd3, 1, 1, 4'd0);
        step(1, 0, 8'h77, 2'd2, 1, 1, 4'd1);
        step(1, 0, 8'h00, 2'd2, 1, 1, 4'd2);
        step(0, 0, 8'h00, 2'd2, 1, 1, 4'd3);
        step(0, 0, 8'h00, 2'd2, 1, 1, 4'd5);
        step(0, 0, 8'h00, 2'd2, 1, 1, 4'd6);

        // Asynchronous reset during CSR2: outputs clear with no clock edge.
        reset = 1'b0;
        #1;
        check_zero_outputs("async_reset");
        #1;
        reset   = 1'b1;
        ref_scr = 33'd1;
        step(1, 0, 8'h00, 2'd2, 1, 1, 4'd1);
        step(1, 0, 8'h00, 2'd2, 1, 1, 4'd2);
        step(0, 0, 8'h00, 2'd2, 1, 1, 4'd3);
        step(0, 0, 8'h00, 2'd2, 1, 1, 4'd5);
        step(0, 0, 8'h00, 2'd2, 1, 1, 4'd6);
        step(0, 0, 8'h00, 2'd2, 1, 1, 4'd7);
        step(0, 0, 8'h00, 2'd2, 1, 1, 4'd8);
        step(0, 0, 8'h00, 2'd2, 1, 1, 4'd1);

        // Scrambler against the reference polynomials: master, then slave.
        for (int i = 0; i < 100; i++)
            step(0, 0, 8'h00, 2'd1, 1, 1, 4'd1);
        for (int i = 0; i < 100; i++)
            step(0, 0, 8'h00, 2'd1, 0, 1, 4'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pcs_tx_framer.md
# pcs_tx_framer

Parametrised 1000BASE-T-style PCS transmit framer. It is the next generation of the `Encoder` framing path, and adds four things that path does not have: configurable lane count and symbol width, end-of-stream extension and error variants, carrier extension, and a side-stream scrambler with master/slave polynomials. It sits between the GMII-side transmit interface and the symbol mapping LUT. Each cycle it emits a symbol class, the fixed framing symbols for that class, and the scrambled data word the LUT consumes.

## Interface
Parameters:
- `LANES`, 4: number of symbol lanes (A..D when 4). Must be ≥ 2.
- `SYM_W`, 3: symbol width, two's complement. Must be ≥ 3.
- `DATA_W`, 8: octet width per cycle.
- `SCR_W`, 33: scrambler LFSR length. Must be ≥ `DATA_W`.
- `TAP_M`, 13: master feedback tap (x^SCR_W + x^TAP_M + 1).
- `TAP_S`, 20: slave feedback tap.
- `SEED`, 1: LFSR reset value. Must be nonzero.

Ports:
- `clock`  in  1: sole clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `io_tx_enable`  in  1: frame-active strobe.
- `io_tx_error`  in  1: transmit error / carrier-extend qualifier.
- `io_tx_data`  in  `DATA_W`: transmit octet.
- `io_tx_mode`  in  2: 0 = SEND_Z, 1 = SEND_I, 2 = SEND_N; 3 is treated as SEND_Z.
- `io_master`  in  1: 1 selects `TAP_M`, 0 selects `TAP_S`. Sampled every cycle.
- `io_loc_rcvr_status`  in  1: 0 suppresses new frame starts.
- `io_kind`  out  4: symbol class code (listed below).
- `io_sym`  out  `LANES*SYM_W`: framing symbols. Lane 0 occupies the MSBs.
- `io_data_out`  out  `DATA_W`: scrambled data word.
- `io_busy`  out  1: high whenever the FSM is outside the IDLE and ZERO states.

## Operation
Kind codes:
- 0 ZERO, 1 IDLE, 2 SSD1, 3 SSD2, 4 DATA, 5 CSR1, 6 CSR2, 7 ESD1.
- 8 ESD2_EXT0, 9 ESD2_EXT1, 10 ESD2_EXT2, 11 ESD2_ERR.
- 12 CEXT, 13 CEXT_ERR, 14 XMT_ERR.

Symbol values:
- P = +2 and M = −2, both `SYM_W`-bit two's complement (3'd2 / 3'd6 at default width).
- SSD1, ESD1: every lane P.
- SSD2, ESD2_EXT0: every lane P except lane `LANES-1`, which is M.
- ESD2_EXT1: lane `LANES-2` is M, all others P.
- ESD2_EXT2: lane 1 is M, all others P.
- ESD2_ERR: lane 0 is M, all others P.
- XMT_ERR: every lane M.
- All other kinds: every lane 0.

FSM states: ZERO, IDLE, SSD1, SSD2, DATA, CSR1, CSR2, ESD1, ESD2, CEXT. The next state is decided from the inputs sampled at each edge.

- **Mode override.** `io_tx_mode` = SEND_Z, from any state, goes to ZERO immediately. Any frame in progress is aborted with no ESD.
- **ZERO.** Leaves to IDLE when the mode is not SEND_Z.
- **IDLE.** Goes to SSD1 when `io_tx_enable` = 1, mode = SEND_N and `io_loc_rcvr_status` = 1. Otherwise stays in IDLE.
- **SSD1, SSD2.** SSD1 always goes to SSD2. The octets presented on these two cycles are preamble and are discarded.
- **SSD2, DATA.**
  - `io_tx_enable` = 1: go to DATA.
  - `io_tx_enable` = 0: go to CSR1.
  - In DATA, `io_tx_error` = 1 emits XMT_ERR in place of DATA for that cycle.
- **Frame end.** CSR1 → CSR2 → ESD1 → ESD2 unconditionally. Inputs are ignored, except the mode override.
- **ESD2 kind**, chosen from the inputs sampled at the ESD1 → ESD2 edge:
  - `io_tx_error` = 0: EXT0.
  - `io_tx_error` = 1 and data = 0x0F: EXT1.
  - `io_tx_error` = 1 and data = 0x1F: EXT2.
  - Any other error case: ERR.
- **After ESD2.**
  - EXT1 or EXT2: go to CEXT.
  - EXT0 or ERR: go to IDLE. The IDLE decision rules apply from the next edge, so back-to-back frames are permitted.
- **CEXT.**
  - Stays while `io_tx_error` = 1.
  - Emits kind CEXT when data = 0x0F, otherwise CEXT_ERR.
  - Goes to IDLE when `io_tx_error` = 0.
- **Receiver status.** `io_loc_rcvr_status` dropping mid-frame has no effect; only new starts are gated.

Scrambler:
- The LFSR advances every cycle while out of reset, in all states including ZERO.
- The new bit is `scr[SCR_W-1] ^ scr[TAP-1]`, shifted into bit 0.
- `io_data_out`:
  - DATA: `io_tx_data ^ scr[DATA_W-1:0]`.
  - IDLE, CSR1, CSR2, ESD1, ESD2, CEXT: `scr[DATA_W-1:0]`.
  - ZERO: 0.
- Changing `io_master` mid-stream takes effect on the next shift. The state is not reseeded.

## Timing
- Every output is registered. Inputs sampled at edge k are reflected in the outputs immediately after edge k, a latency of one cycle.
- Frame timeline, with enable first sampled high at edge 0 and first sampled low at edge L:
  - SSD1 follows edge 0 and SSD2 follows edge 1.
  - DATA (or XMT_ERR) follows edges 2 … L−1.
  - CSR1 follows edge L, then CSR2, ESD1 and ESD2 on the next three edges.
- A frame whose enable is shorter than 3 cycles still emits SSD1, SSD2, CSR1, CSR2, ESD1, ESD2.
- Reset is asynchronous: `reset` = 0 forces the following immediately, independent of the clock:
  - FSM state ZERO.
  - `io_kind` = 0, `io_sym` = 0, `io_data_out` = 0, `io_busy` = 0.
  - LFSR = `SEED`.
- Reset release is synchronous. The first edge after release is the first to update state.
- Reset asserted mid-frame truncates the frame with no ESD.

## Test plan
- **Framing.** Release reset; mode = 2, rcvr = 1, enable high for 6 cycles with data 0xF0 → kinds 2, 3, 4, 4, 4, 4, 5, 6, 7, 8, 1. `io_sym` = 0x492 on SSD1, 0x496 on SSD2, 0x492 on ESD1, 0x496 on ESD2_EXT0.
- **ESD2 variants.** At the ESD1 → ESD2 edge drive in turn error = 1 with data 0x0F, error = 1 with 0x1F, and error = 1 with 0x33 → ESD2 `io_sym` = 0x4B2 (EXT1), 0x592 (EXT2), 0xC92 (ERR). EXT1 and EXT2 are followed by CEXT until the error drops, then IDLE.
- **Scrambler.** With `SEED` = 1, master, enable = 0 → `io_data_out` matches a reference x^33+x^13+1 model for 100 cycles. Repeat with `io_master` = 0 against x^33+x^20+1.
- **Data error and gating.** Error = 1 during a DATA cycle → kind 14, `io_sym` = 0xDB6. Rcvr status = 0 in IDLE with enable high → stays in IDLE, `io_busy` = 0.
- **Mode override.** Mode → 0 during DATA → ZERO on the next cycle, all outputs 0, no ESD. Mode → 2 → IDLE, then SSD1 if enable is high.
- **Mid-frame reset.** Assert reset during CSR2 → outputs zero immediately, without waiting for a clock edge; LFSR = `SEED`. After release, the first frame starts cleanly with SSD1.
